// File: rtl/dmem_pkg.sv
// dmem_pkg: access-size codes, FSM states and byte-lane mask helper for dmem_sized
package dmem_pkg;

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;
    localparam logic [1:0] SZ_RSVD = 2'b11;

    typedef enum logic {ST_CLEAR, ST_IDLE} state_e;

    function automatic logic [3:0] lane_mask(input logic [1:0] size, input logic [1:0] off);
        return size == SZ_BYTE ? 4'b0001 << off :
               size == SZ_HALF ? (off[1] ? 4'b1100 : 4'b0011) :
               size == SZ_WORD ? 4'b1111 : 4'b0000;
    endfunction

endpackage

// File: rtl/dmem_bram_be.sv
// dmem_bram_be: single-port word RAM with byte-lane write enables and registered read
module dmem_bram_be #(
  parameter int    DEPTH_WORDS = 16384,
  parameter string INIT_FILE   = "",
  localparam int   IDX_W       = $clog2(DEPTH_WORDS)
) (
  input  logic             clock_i,
  input  logic [IDX_W-1:0] addr_i,
  input  logic [3:0]       we_i,
  input  logic [31:0]      wdata_i,
  output logic [31:0]      rdata_o
);
  logic [31:0] mem_q [DEPTH_WORDS];
  always_ff @(posedge clock_i) begin
    for (int i = 0; i < 4; i++)
      if (we_i[i]) mem_q[addr_i][8*i +: 8] <= wdata_i[8*i +: 8];
    rdata_o <= mem_q[addr_i];
  end
endmodule

// File: rtl/dmem_sized.sv
// dmem_sized: sized load/store data memory with clear-after-reset, misalignment check and 1-cycle response
module dmem_sized
    import dmem_pkg::*;
#(
    parameter int    DEPTH_WORDS    = 16384,
    parameter int    ADDR_W         = 32,
    parameter int    CLEAR_ON_RESET = 1,
    parameter string INIT_FILE      = ""
) (
    input  logic              clock_i,
    input  logic              reset_i,
    input  logic              req_valid_i,
    output logic              req_ready_o,
    input  logic              mem_write_i,
    input  logic [1:0]        size_i,
    input  logic              sign_ext_i,
    input  logic [ADDR_W-1:0] address_i,
    input  logic [31:0]       write_data_i,
    output logic              resp_valid_o,
    output logic [31:0]       read_data_o,
    output logic              misalign_err_o
);

    localparam int IDX_W = $clog2(DEPTH_WORDS);

    state_e           state_q;
    logic [IDX_W-1:0] clr_q;
    logic             ready_q;
    logic             resp_valid_q, load_q, err_q, sext_q;
    logic [1:0]       size_q, off_q;
    logic [1:0]       off;
    logic             err, accept, clearing;
    logic [IDX_W-1:0] ram_addr;
    logic [3:0]       ram_we;
    logic [31:0]      ram_wdata, ram_rdata, wdata_rep;
    logic [7:0]       byte_w;
    logic [15:0]      half_w;
    logic [31:0]      ext;

    assign off      = address_i[1:0];
    assign err      = size_i == SZ_RSVD || (size_i == SZ_HALF && off[0]) || (size_i == SZ_WORD && off != 2'b00);
    assign accept   = req_valid_i && ready_q;
    assign clearing = state_q == ST_CLEAR;

    // Narrow stores replicate data across lanes; the lane mask picks the live ones.
    assign wdata_rep = size_i == SZ_BYTE ? {4{write_data_i[7:0]}} :
                       size_i == SZ_HALF ? {2{write_data_i[15:0]}} : write_data_i;
    assign ram_addr  = clearing ? clr_q : address_i[IDX_W+1:2];
    assign ram_we    = clearing ? 4'hF : (accept && mem_write_i && !err) ? lane_mask(size_i, off) : 4'h0;
    assign ram_wdata = clearing ? 32'h0 : wdata_rep;

    generate
        if (ADDR_W > IDX_W + 2) begin : g_alias
            logic unused_hi;
            assign unused_hi = ^address_i[ADDR_W-1:IDX_W+2];
        end
    endgenerate

    dmem_bram_be #(.DEPTH_WORDS(DEPTH_WORDS), .INIT_FILE(INIT_FILE)) u_ram (
        .clock_i(clock_i),
        .addr_i (ram_addr),
        .we_i   (ram_we),
        .wdata_i(ram_wdata),
        .rdata_o(ram_rdata)
    );

    always_ff @(posedge clock_i) begin
        if (reset_i) begin
            state_q <= CLEAR_ON_RESET != 0 ? ST_CLEAR : ST_IDLE;
            clr_q   <= '0;
            ready_q <= 1'b0;
        end else if (state_q == ST_CLEAR) begin
            clr_q <= clr_q + IDX_W'(1);
            if (clr_q == IDX_W'(DEPTH_WORDS - 1)) begin
                state_q <= ST_IDLE;
                ready_q <= 1'b1;
            end
        end else begin
            ready_q <= 1'b1;
        end
    end

    always_ff @(posedge clock_i) begin
        if (reset_i) begin
            resp_valid_q <= 1'b0;
            load_q       <= 1'b0;
            err_q        <= 1'b0;
            sext_q       <= 1'b0;
            size_q       <= SZ_BYTE;
            off_q        <= 2'b00;
        end else begin
            resp_valid_q <= accept;
            load_q       <= accept && !mem_write_i && !err;
            err_q        <= accept && err;
            sext_q       <= sign_ext_i;
            size_q       <= size_i;
            off_q        <= off;
        end
    end

    assign byte_w = ram_rdata[8*off_q +: 8];
    assign half_w = off_q[1] ? ram_rdata[31:16] : ram_rdata[15:0];
    assign ext    = size_q == SZ_BYTE ? {{24{sext_q && byte_w[7]}}, byte_w} :
                    size_q == SZ_HALF ? {{16{sext_q && half_w[15]}}, half_w} : ram_rdata;

    assign req_ready_o    = ready_q;
    assign resp_valid_o   = resp_valid_q;
    assign read_data_o    = load_q ? ext : 32'h0;
    assign misalign_err_o = err_q;

endmodule

// File: tb/tb_dmem_sized.sv
// tb_dmem_sized: table vectors, reset/clear sequences and randomized traffic against a byte-array model
module tb_dmem_sized;

    localparam int DEPTH = 16;

    logic        clk = 1'b0;
    logic        reset_i = 1'b1;
    logic        req_valid_i = 1'b0;
    logic        mem_write_i = 1'b0;
    logic [1:0]  size_i = 2'b00;
    logic        sign_ext_i = 1'b0;
    logic [31:0] address_i = 32'h0;
    logic [31:0] write_data_i = 32'h0;
    logic        req_ready_o, resp_valid_o, misalign_err_o;
    logic [31:0] read_data_o;

    int n_chk = 0;
    int n_fail = 0;
    logic [7:0] mm [DEPTH*4];

    typedef struct {
        logic        we;
        logic [1:0]  sz;
        logic        sx;
        logic [31:0] a;
        logic [31:0] wd;
        logic [31:0] rd;
        logic        err;
    } vec_t;
    vec_t tv[$];

    always #5 clk = ~clk;

    dmem_sized #(.DEPTH_WORDS(DEPTH), .ADDR_W(32), .CLEAR_ON_RESET(1), .INIT_FILE("")) dut (
        .clock_i       (clk),
        .reset_i       (reset_i),
        .req_valid_i   (req_valid_i),
        .req_ready_o   (req_ready_o),
        .mem_write_i   (mem_write_i),
        .size_i        (size_i),
        .sign_ext_i    (sign_ext_i),
        .address_i     (address_i),
        .write_data_i  (write_data_i),
        .resp_valid_o  (resp_valid_o),
        .read_data_o   (read_data_o),
        .misalign_err_o(misalign_err_o)
    );

    task automatic cyc;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // Little-endian byte-array view of memory; sizes in bytes, alignment by modulo.
    task automatic mdl(input logic we, input logic [1:0] sz, input logic sx, input logic [31:0] a,
                       input logic [31:0] wd, output logic err, output logic [31:0] rd);
        int base, off, nb;
        logic [31:0] v;
        base = int'((a >> 2) % DEPTH) * 4;
        off  = int'(a % 4);
        nb   = sz == 2'd0 ? 1 : sz == 2'd1 ? 2 : sz == 2'd2 ? 4 : 0;
        err  = nb == 0 ? 1'b1 : (off % nb) != 0;
        rd   = 32'h0;
        if (!err) begin
            if (we) begin
                for (int i = 0; i < nb; i++) mm[base+off+i] = wd[8*i +: 8];
            end else begin
                v = 32'h0;
                for (int i = 0; i < nb; i++) v |= 32'(mm[base+off+i]) << (8*i);
                if (sx && nb < 4 && v[8*nb-1]) v |= 32'hFFFF_FFFF << (8*nb);
                rd = v;
            end
        end
    endtask

    task automatic req(input logic we, input logic [1:0] sz, input logic sx, input logic [31:0] a,
                       input logic [31:0] wd, output logic m_err, output logic [31:0] m_rd);
        req_valid_i  = 1'b1;
        mem_write_i  = we;
        size_i       = sz;
        sign_ext_i   = sx;
        address_i    = a;
        write_data_i = wd;
        cyc;
        req_valid_i = 1'b0;
        mdl(we, sz, sx, a, wd, m_err, m_rd);
    endtask

    task automatic count_clear(input string nm);
        int n, bad;
        n = 0;
        bad = 0;
        while (!req_ready_o && n < 100) begin
            n++;
            if (resp_valid_o) bad++;
            cyc;
        end
        chk({nm, " clear cycles"}, n, 16);
        chk({nm, " resp during clear"}, bad, 0);
    endtask

    initial begin
        logic        e;
        logic [31:0] r;
        for (int i = 0; i < DEPTH*4; i++) mm[i] = 8'h00;

        repeat (3) cyc;
        chk("reset ready", req_ready_o, 0);
        chk("reset resp_valid", resp_valid_o, 0);
        chk("reset read_data", read_data_o, 0);
        chk("reset err", misalign_err_o, 0);
        reset_i = 1'b0;
        count_clear("init");

        tv.push_back('{1'b0, 2'd2, 1'b0, 32'h3C, 32'h0,        32'h0000_0000, 1'b0});
        tv.push_back('{1'b1, 2'd2, 1'b0, 32'h08, 32'h80FF7F01, 32'h0000_0000, 1'b0});
        tv.push_back('{1'b0, 2'd0, 1'b1, 32'h08, 32'h0,        32'h0000_0001, 1'b0});
        tv.push_back('{1'b0, 2'd0, 1'b1, 32'h0A, 32'h0,        32'hFFFF_FFFF, 1'b0});
        tv.push_back('{1'b0, 2'd0, 1'b0, 32'h0B, 32'h0,        32'h0000_0080, 1'b0});
        tv.push_back('{1'b0, 2'd1, 1'b1, 32'h0A, 32'h0,        32'hFFFF_80FF, 1'b0});
        tv.push_back('{1'b0, 2'd1, 1'b0, 32'h08, 32'h0,        32'h0000_7F01, 1'b0});
        tv.push_back('{1'b1, 2'd2, 1'b0, 32'h04, 32'h0,        32'h0000_0000, 1'b0});
        tv.push_back('{1'b1, 2'd0, 1'b0, 32'h06, 32'h0000_00AB, 32'h0000_0000, 1'b0});
        tv.push_back('{1'b1, 2'd1, 1'b0, 32'h04, 32'h0000_1234, 32'h0000_0000, 1'b0});
        tv.push_back('{1'b0, 2'd2, 1'b0, 32'h04, 32'h0,        32'h00AB_1234, 1'b0});
        tv.push_back('{1'b1, 2'd1, 1'b0, 32'h05, 32'h0000_FFFF, 32'h0000_0000, 1'b1});
        tv.push_back('{1'b0, 2'd2, 1'b0, 32'h02, 32'h0,        32'h0000_0000, 1'b1});
        tv.push_back('{1'b0, 2'd3, 1'b0, 32'h00, 32'h0,        32'h0000_0000, 1'b1});
        tv.push_back('{1'b0, 2'd2, 1'b0, 32'h00, 32'h0,        32'h0000_0000, 1'b0});
        tv.push_back('{1'b0, 2'd2, 1'b0, 32'h04, 32'h0,        32'h00AB_1234, 1'b0});
        tv.push_back('{1'b1, 2'd2, 1'b0, 32'h10, 32'hDEADBEEF, 32'h0000_0000, 1'b0});
        tv.push_back('{1'b0, 2'd2, 1'b0, 32'h10, 32'h0,        32'hDEAD_BEEF, 1'b0});
        tv.push_back('{1'b0, 2'd2, 1'b0, 32'h50, 32'h0,        32'hDEAD_BEEF, 1'b0});
        tv.push_back('{1'b1, 2'd2, 1'b0, 32'h54, 32'h11223344, 32'h0000_0000, 1'b0});
        tv.push_back('{1'b0, 2'd2, 1'b0, 32'h14, 32'h0,        32'h1122_3344, 1'b0});
        tv.push_back('{1'b0, 2'd1, 1'b0, 32'h12, 32'h0,        32'h0000_DEAD, 1'b0});
        tv.push_back('{1'b0, 2'd0, 1'b1, 32'h13, 32'h0,        32'hFFFF_FFDE, 1'b0});
        tv.push_back('{1'b0, 2'd1, 1'b1, 32'h10, 32'h0,        32'hFFFF_BEEF, 1'b0});
        tv.push_back('{1'b1, 2'd0, 1'b0, 32'h11, 32'h1234565A, 32'h0000_0000, 1'b0});
        tv.push_back('{1'b0, 2'd2, 1'b0, 32'h10, 32'h0,        32'hDEAD_5AEF, 1'b0});
        tv.push_back('{1'b0, 2'd0, 1'b0, 32'h01, 32'h0,        32'h0000_0000, 1'b0});

        for (int i = 0; i < tv.size(); i++) begin
            req(tv[i].we, tv[i].sz, tv[i].sx, tv[i].a, tv[i].wd, e, r);
            chk($sformatf("vec%0d resp_valid", i), resp_valid_o, 1);
            chk($sformatf("vec%0d read_data", i), read_data_o, tv[i].rd);
            chk($sformatf("vec%0d misalign_err", i), misalign_err_o, tv[i].err);
        end
        cyc;
        chk("idle resp_valid", resp_valid_o, 0);
        chk("idle read_data", read_data_o, 0);
        chk("idle err", misalign_err_o, 0);

        for (int k = 0; k < 400; k++) begin
            if ($urandom_range(3) != 0) begin
                req(1'($urandom), 2'($urandom), 1'($urandom), $urandom_range(DEPTH*8-1), $urandom, e, r);
                chk($sformatf("rnd%0d resp_valid", k), resp_valid_o, 1);
                chk($sformatf("rnd%0d read_data", k), read_data_o, r);
                chk($sformatf("rnd%0d misalign_err", k), misalign_err_o, e);
            end else begin
                cyc;
                chk($sformatf("rnd%0d idle resp_valid", k), resp_valid_o, 0);
                chk($sformatf("rnd%0d idle read_data", k), read_data_o, 0);
            end
        end

        req(1'b1, 2'd2, 1'b0, 32'h10, 32'hCAFE_F00D, e, r);
        reset_i = 1'b1;
        cyc;
        reset_i = 1'b0;
        req_valid_i = 1'b1;
        repeat (7) cyc;
        reset_i = 1'b1;
        cyc;
        reset_i = 1'b0;
        count_clear("restart");
        req_valid_i = 1'b0;
        for (int i = 0; i < DEPTH*4; i++) mm[i] = 8'h00;

        req(1'b0, 2'd2, 1'b0, 32'h10, 32'h0, e, r);
        chk("post-clear resp_valid", resp_valid_o, 1);
        chk("post-clear lw 0x10", read_data_o, 32'h0);
        for (int k = 0; k < 100; k++) begin
            req(1'($urandom), 2'($urandom), 1'($urandom), $urandom_range(DEPTH*8-1), $urandom, e, r);
            chk($sformatf("rnd2_%0d read_data", k), read_data_o, r);
            chk($sformatf("rnd2_%0d misalign_err", k), misalign_err_o, e);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
